// File: rtl/commit_arb_s.sv
// commit_arb_s: upstream commit arbiter for the scalar reorder buffer.
// Each of five sources (0=LdSt1, 1=LdSt2, 2=Math, 3=Mv, 4=V) owns one
// pending slot. A round-robin search over the slots loads a single
// registered commit stream that is handed off with a valid/ack handshake.
// Optional macro COMMIT_ARB_BYPASS_EN: when every slot is empty and the
// output register is free, the lowest-index requester goes straight into
// the output register and skips its pending slot.
module commit_arb_s #(
    parameter int NUM_SRC   = 5,
    parameter int WIDTH_SRC = 3,
    parameter int WIDTH_NO  = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_SRC-1:0]                 I_Req,
    input  logic [NUM_SRC-1:0][WIDTH_NO-1:0]   I_No,
    output logic [NUM_SRC-1:0]                 O_Grant,
    output logic                               O_Commit_Req,
    output logic [WIDTH_NO-1:0]                O_Commit_No,
    output logic [WIDTH_SRC-1:0]               O_Commit_Src,
    input  logic                               I_Commit_Ack,
    output logic [NUM_SRC-1:0]                 O_Pend,
    output logic                               O_Empty
);

    logic [NUM_SRC-1:0]               pend_v_q, pend_v_d;
    logic [NUM_SRC-1:0][WIDTH_NO-1:0] pend_no_q, pend_no_d;
    logic                             out_v_q, out_v_d;
    logic [WIDTH_NO-1:0]              out_no_q, out_no_d;
    logic [WIDTH_SRC-1:0]             out_src_q, out_src_d;
    logic [WIDTH_SRC-1:0]             ptr_q, ptr_d;

    logic                             out_free;
    logic                             load;
    logic [WIDTH_SRC-1:0]             sel;
    logic [WIDTH_SRC-1:0]             idx;
    logic                             found;
    logic [NUM_SRC-1:0]               drain;
    logic [NUM_SRC-1:0]               cap;

    logic                             byp_v;
    logic [WIDTH_SRC-1:0]             byp_sel;
    logic [NUM_SRC-1:0]               byp_mask;

    assign out_free = ~out_v_q | I_Commit_Ack;
    assign load     = out_free & (|pend_v_q);

    // Round-robin search: first valid slot after ptr_q, wrapping at NUM_SRC-1.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = ptr_q;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (idx == WIDTH_SRC'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
            if (!found && pend_v_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign drain = load ? (NUM_SRC'(1) << sel) : '0;

`ifdef COMMIT_ARB_BYPASS_EN
    // Bypass select: lowest-index requester while all slots are empty.
    always_comb begin
        byp_sel  = '0;
        byp_v    = 1'b0;
        byp_mask = '0;
        if (out_free && !(|pend_v_q)) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (!byp_v && I_Req[i]) begin
                    byp_v       = 1'b1;
                    byp_sel     = WIDTH_SRC'(i);
                    byp_mask[i] = 1'b1;
                end
            end
        end
    end
`else
    assign byp_v    = 1'b0;
    assign byp_sel  = '0;
    assign byp_mask = '0;
`endif

    // A source may hand over whenever its slot is empty or being drained now.
    assign O_Grant = ~pend_v_q | drain;
    assign cap     = I_Req & O_Grant & ~byp_mask;

    // Slot update: capture wins over drain so a same-cycle refill keeps the slot valid.
    always_comb begin
        pend_v_d  = pend_v_q;
        pend_no_d = pend_no_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (cap[i]) begin
                pend_v_d[i]  = 1'b1;
                pend_no_d[i] = I_No[i];
            end else if (drain[i]) begin
                pend_v_d[i] = 1'b0;
            end
        end
    end

    // Output register: load from the selected slot (or bypass), else clear on ack.
    always_comb begin
        out_v_d   = out_v_q;
        out_no_d  = out_no_q;
        out_src_d = out_src_q;
        ptr_d     = ptr_q;
        if (load) begin
            out_v_d   = 1'b1;
            out_no_d  = pend_no_q[sel];
            out_src_d = sel;
            ptr_d     = sel;
        end else if (byp_v) begin
            out_v_d   = 1'b1;
            out_no_d  = I_No[byp_sel];
            out_src_d = byp_sel;
            ptr_d     = byp_sel;
        end else if (I_Commit_Ack && out_v_q) begin
            out_v_d = 1'b0;
        end
    end

    // State registers; reset drops all pending and in-flight commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_v_q  <= '0;
            pend_no_q <= '0;
            out_v_q   <= 1'b0;
            out_no_q  <= '0;
            out_src_q <= '0;
            ptr_q     <= WIDTH_SRC'(NUM_SRC - 1);
        end else begin
            pend_v_q  <= pend_v_d;
            pend_no_q <= pend_no_d;
            out_v_q   <= out_v_d;
            out_no_q  <= out_no_d;
            out_src_q <= out_src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign O_Commit_Req = out_v_q;
    assign O_Commit_No  = out_no_q;
    assign O_Commit_Src = out_src_q;
    assign O_Pend       = pend_v_q;
    assign O_Empty      = ~(|pend_v_q) & ~out_v_q;

endmodule

// File: tb/tb_commit_arb_s.sv
// Bench for commit_arb_s: directed scenarios plus random traffic, checked
// against a slot-level reference model; committed transfers are matched
// against an expected-commit queue by an independent monitor.
module tb_commit_arb_s;

    localparam int N = 5;
    localparam int W = 8;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [N-1:0]          I_Req = '0;
    logic [N-1:0][W-1:0]   I_No = '0;
    logic [N-1:0]          O_Grant;
    logic                  O_Commit_Req;
    logic [W-1:0]          O_Commit_No;
    logic [2:0]            O_Commit_Src;
    logic                  I_Commit_Ack = 1'b0;
    logic [N-1:0]          O_Pend;
    logic                  O_Empty;

    commit_arb_s #(.NUM_SRC(N), .WIDTH_SRC(3), .WIDTH_NO(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req        (I_Req),
        .I_No         (I_No),
        .O_Grant      (O_Grant),
        .O_Commit_Req (O_Commit_Req),
        .O_Commit_No  (O_Commit_No),
        .O_Commit_Src (O_Commit_Src),
        .I_Commit_Ack (I_Commit_Ack),
        .O_Pend       (O_Pend),
        .O_Empty      (O_Empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        int src;
        int no;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // source side: each source holds its request until it is accepted
    bit s_busy[N];
    int s_no[N];

    // reference model of slots and output register
    bit m_pv[N];
    int m_pn[N];
    bit m_ov;
    int m_ptr;
    int m_no;
    int m_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pv[i]   = 1'b0;
            m_pn[i]   = 0;
            s_busy[i] = 1'b0;
        end
        m_ov  = 1'b0;
        m_ptr = N - 1;
        m_no  = 0;
        m_src = 0;
        expq.delete();
    endtask

    task automatic offer(input int i, input int no);
        s_busy[i] = 1'b1;
        s_no[i]   = no;
    endtask

    // One clock: drive at negedge, check visible state, advance the model.
    task automatic step(input bit ack);
        logic [N-1:0] g;
        logic [N-1:0] pv_vec;
        bit anyp, free, load, byp, acc;
        int sel, bsel, j;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            I_Req[i] = s_busy[i];
            I_No[i]  = 8'(s_no[i]);
        end
        I_Commit_Ack = ack;
        #1;
        anyp = 1'b0;
        for (int i = 0; i < N; i++) begin
            pv_vec[i] = m_pv[i];
            if (m_pv[i]) anyp = 1'b1;
        end
        free = !m_ov || ack;
        load = free && anyp;
        sel  = -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_ptr + k) % N;
            if (sel < 0 && m_pv[j]) sel = j;
        end
        bsel = -1;
        byp  = 1'b0;
`ifdef COMMIT_ARB_BYPASS_EN
        if (!anyp && free) begin
            for (int i = 0; i < N; i++)
                if (bsel < 0 && s_busy[i]) bsel = i;
            byp = (bsel >= 0);
        end
`endif
        for (int i = 0; i < N; i++)
            g[i] = !m_pv[i] || (load && sel == i);

        chk("grant", O_Grant, g);
        chk("pend", O_Pend, pv_vec);
        chk("empty", O_Empty, (!anyp && !m_ov));
        chk("commit_req", O_Commit_Req, m_ov);
        if (m_ov) begin
            chk("hold_no", O_Commit_No, m_no);
            chk("hold_src", O_Commit_Src, m_src);
        end

        if (load) begin
            expq.push_back('{src: sel, no: m_pn[sel]});
            m_ov = 1'b1; m_no = m_pn[sel]; m_src = sel; m_ptr = sel;
        end else if (byp) begin
            expq.push_back('{src: bsel, no: s_no[bsel]});
            m_ov = 1'b1; m_no = s_no[bsel]; m_src = bsel; m_ptr = bsel;
        end else if (ack && m_ov) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            acc = s_busy[i] && g[i];
            if (acc && !(byp && i == bsel)) begin
                m_pv[i] = 1'b1;
                m_pn[i] = s_no[i];
            end else if (load && sel == i) begin
                m_pv[i] = 1'b0;
            end
            if (acc) s_busy[i] = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, O_Commit_Req, 0);
        chk({tag, "_no"}, O_Commit_No, 0);
        chk({tag, "_src"}, O_Commit_Src, 0);
        chk({tag, "_pend"}, O_Pend, 0);
        chk({tag, "_empty"}, O_Empty, 1);
        chk({tag, "_grant"}, O_Grant, 5'b11111);
    endtask

    // Called right after step(): reset lands before that step's clock edge.
    task automatic reset_mid();
        #2;
        reset = 1'b1;
        I_Req = '0;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every accepted commit must match the queue head.
    always @(negedge clock) begin
        #2;
        if (!reset && O_Commit_Req && I_Commit_Ack) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL commit_unexpected: got src=%0d no=0x%0h expected none at %0t",
                         O_Commit_Src, O_Commit_No, $time);
            end else begin
                mon_e = expq.pop_front();
                chk("commit_src", O_Commit_Src, mon_e.src);
                chk("commit_no", O_Commit_No, mon_e.no);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        check_reset_values("rst_init");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // reset while busy: out valid, slots 1,2,4 pending
        offer(0, 8'h50); offer(1, 8'h51); offer(2, 8'h52); offer(4, 8'h54);
        repeat (3) step(1'b0);
        reset_mid();

        // single Math request
        offer(2, 8'h2A);
        repeat (4) step(1'b1);

        // all five in one cycle
        for (int i = 0; i < N; i++) offer(i, i + 1);
        repeat (8) step(1'b1);

        // backpressure with LdSt1 and V pending, second LdSt1 held
        offer(0, 8'h60); offer(4, 8'h64);
        step(1'b0);
        step(1'b0);
        offer(0, 8'h61);
        step(1'b0);
        offer(0, 8'h62);
        repeat (4) step(1'b0);
        repeat (8) step(1'b1);

        // round-robin wrap after a V commit
        offer(4, 8'h70);
        repeat (3) step(1'b1);
        offer(1, 8'h71); offer(4, 8'h74);
        repeat (6) step(1'b1);

        // same-cycle drain and capture on Mv
        offer(0, 8'h20);
        step(1'b1);
        step(1'b0);
        offer(3, 8'h10);
        step(1'b0);
        offer(3, 8'h11);
        repeat (6) step(1'b1);

        // random traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++)
                if (!s_busy[i] && $urandom_range(0, 2) == 0)
                    offer(i, $urandom_range(0, 255));
            step($urandom_range(0, 9) < 7);
        end

        // drain
        repeat (15) step(1'b1);
        @(negedge clock);
        #3;
        chk("final_queue", expq.size(), 0);
        chk("final_empty", O_Empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
